demux_deser_1_8: RTL and testbench
==================================

Name: demux_deser_1_8

Overview:
- Sequential 1-to-8 demultiplexer and deserializer; the receive-side counterpart of the team's 8:1 mux tree used as a serializer.
- A 3-bit slot counter steers each incoming serial bit into one of 8 slots of a shadow register.
- Each completed byte is presented on a parallel output with a valid/ready handshake.
- Sits after any serial link that is driven by an 8:1 mux stepping S from 0 to 7.

Parameters:
- LSB_FIRST, 1: 1 means slot n receives bit n of the byte; 0 means slot n receives bit 7-n.
- CLEAR_ON_SYNC, 1: 1 means frame_start without din_valid zeroes the shadow register; 0 means the shadow register is left unchanged.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled on this edge.
- frame_start  in  1  resynchronises the slot counter to slot 0.
- sel  out  3  current slot index; the bit captured on the next valid edge goes to this slot.
- dout  out  8  assembled byte.
- dout_valid  out  1  dout holds an unconsumed byte.
- dout_ready  in  1  consumer accepts dout on this edge when dout_valid=1.
- overrun  out  1  sticky flag: a completed byte was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (asynchronous, any time, including mid-byte):
  - sel=0, shadow=0, dout=8'h00, dout_valid=0, overrun=0.
  - A partial byte is lost.
  - No output changes until the first clk edge after rst deasserts.
- Capture, on an edge with din_valid=1:
  - shadow[slot(sel)] <= din.
  - sel <= sel+1, wrapping from 7 to 0.
  - On an edge with din_valid=0, sel and shadow hold.
- Completion: an edge with din_valid=1, sel=7 and frame_start=0 completes a byte. The completed byte is shadow with the just-captured bit merged in.
- Output transfer:
  - If dout_valid=0, or dout_valid=1 and dout_ready=1 on the completion edge: dout <= completed byte and dout_valid <= 1.
  - Latency: dout_valid rises in the cycle after the 8th bit's edge.
- Overrun:
  - If dout_valid=1 and dout_ready=0 on the completion edge: the completed byte is dropped, dout is unchanged, and overrun <= 1.
- Handshake:
  - dout_valid=1 and dout_ready=1 with no completion on that edge: dout_valid <= 0 and dout holds its value.
  - dout_ready while dout_valid=0 is ignored.
  - dout and dout_valid never change except via reset, transfer or accept.
- frame_start with din_valid=1:
  - The bit goes to slot 0 and sel <= 1.
  - The previous partial byte is discarded and no completion occurs, even if sel was 7.
- frame_start with din_valid=0:
  - sel <= 0.
  - Shadow is zeroed if CLEAR_ON_SYNC=1.
- Sticky overrun:
  - clr_overrun=1 clears overrun on the next edge.
  - If an overrun event and clr_overrun occur on the same edge, the set wins and overrun=1.
- The shadow register does not need to be cleared after completion, because every slot is rewritten before the next completion.
- Counter width is exactly 3 bits; wrap is natural modulo-8.

Test Plan:
- Reset, then 8 valid bits 1,0,1,1,0,0,1,0 with LSB_FIRST=1 and dout_ready=1 → dout=8'h4D and dout_valid=1 one cycle after the 8th bit; sel returns to 0.
- Same bit sequence with LSB_FIRST=0 → dout=8'hB2.
- Two back-to-back bytes 8'hA5 then 8'h3C with dout_ready=0 → dout stays 8'hA5, dout_valid=1 and overrun=1; then pulse dout_ready → dout_valid=0; then clr_overrun → overrun=0.
- Send 5 bits, then frame_start with din_valid=1 and din=1, then 7 more bits forming 8'hFF → a single byte 8'hFF, with no byte emitted for the partial 5 bits.
- din_valid gaps: bits for 8'h81 spread across 20 cycles → sel advances only on valid edges; dout=8'h81.
- Assert rst asynchronously (between edges) after 4 bits → sel, dout, dout_valid and overrun are 0 immediately; a following full 8'h0F is received correctly.

Source files
------------

// File: rtl/demux_deser_1_8.sv
// Serial-to-parallel 1:8 demux: a 3-bit slot counter steers serial bits
// into a shadow register and completed bytes leave on a valid/ready port.
module demux_deser_1_8 #(
  parameter bit LSB_FIRST     = 1'b1,
  parameter bit CLEAR_ON_SYNC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_start,
  output logic [2:0] sel,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       overrun,
  input  logic       clr_overrun
);

  logic [2:0] sel_q, sel_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] dout_q, dout_d;
  logic       dv_q, dv_d;
  logic       ovr_q, ovr_d;
  logic       complete;
  logic       ovr_set;

  // MSB-first streams fill the byte from bit 7 downward.
  function automatic logic [2:0] slot_of(input logic [2:0] s);
    return LSB_FIRST ? s : ~s;
  endfunction

  always_comb begin
    sel_d    = sel_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    dv_d     = dv_q;
    complete = 1'b0;
    ovr_set  = 1'b0;

    if (din_valid) begin
      if (frame_start) begin
        shadow_d[slot_of(3'd0)] = din;
        sel_d = 3'd1;
      end else begin
        shadow_d[slot_of(sel_q)] = din;
        sel_d    = sel_q + 3'd1;
        complete = (sel_q == 3'd7);
      end
    end else if (frame_start) begin
      sel_d = 3'd0;
      if (CLEAR_ON_SYNC)
        shadow_d = 8'h00;
    end

    if (complete) begin
      if (!dv_q || dout_ready) begin
        dout_d = shadow_d;
        dv_d   = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (dv_q && dout_ready) begin
      dv_d = 1'b0;
    end

    // A new drop outranks a simultaneous clear.
    if (ovr_set)
      ovr_d = 1'b1;
    else if (clr_overrun)
      ovr_d = 1'b0;
    else
      ovr_d = ovr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= 3'd0;
      shadow_q <= 8'h00;
      dout_q   <= 8'h00;
      dv_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_demux_deser_1_8.sv
// Directed bench for demux_deser_1_8: an LSB-first and an MSB-first
// instance share one stimulus stream.
module tb_demux_deser_1_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       dout_ready = 1'b0;
  logic       clr_overrun = 1'b0;

  logic [2:0] sel_l, sel_m;
  logic [7:0] dout_l, dout_m;
  logic       dv_l, dv_m;
  logic       ovr_l, ovr_m;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  demux_deser_1_8 #(.LSB_FIRST(1'b1), .CLEAR_ON_SYNC(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .sel(sel_l), .dout(dout_l),
    .dout_valid(dv_l), .dout_ready(dout_ready),
    .overrun(ovr_l), .clr_overrun(clr_overrun)
  );

  demux_deser_1_8 #(.LSB_FIRST(1'b0), .CLEAR_ON_SYNC(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .sel(sel_m), .dout(dout_m),
    .dout_valid(dv_m), .dout_ready(dout_ready),
    .overrun(ovr_m), .clr_overrun(clr_overrun)
  );

  task automatic drive(input logic b, input logic v, input logic fs,
                       input logic rdy, input logic clr);
    @(negedge clk);
    din         = b;
    din_valid   = v;
    frame_start = fs;
    dout_ready  = rdy;
    clr_overrun = clr;
  endtask

  task automatic send_bit(input logic b);
    drive(b, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({sel_l, dout_l, dv_l, ovr_l} !== 13'd0)
      $display("FAIL reset_lsb got sel=%0d dout=%h v=%b o=%b want 0",
               sel_l, dout_l, dv_l, ovr_l);
    else pass_cnt++;
    total++;
    if ({sel_m, dout_m, dv_m, ovr_m} !== 13'd0)
      $display("FAIL reset_msb got sel=%0d dout=%h v=%b o=%b want 0",
               sel_m, dout_m, dv_m, ovr_m);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] bits;
    bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) send_bit(bits[i]);
    idle();
    total++;
    if (dv_l !== 1'b1 || dout_l !== 8'h4D)
      $display("FAIL basic_lsb got v=%b dout=%h want v=1 dout=4d", dv_l, dout_l);
    else pass_cnt++;
    total++;
    if (dv_m !== 1'b1 || dout_m !== 8'hB2)
      $display("FAIL basic_msb got v=%b dout=%h want v=1 dout=b2", dv_m, dout_m);
    else pass_cnt++;
    total++;
    if (sel_l !== 3'd0 || sel_m !== 3'd0)
      $display("FAIL basic_sel got %0d/%0d want 0/0", sel_l, sel_m);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    total++;
    if (dv_l !== 1'b0 || dout_l !== 8'h4D)
      $display("FAIL basic_accept got v=%b dout=%h want v=0 dout=4d", dv_l, dout_l);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send_byte(8'hA5);
    send_byte(8'h3C);
    idle();
    total++;
    if (dout_l !== 8'hA5 || dv_l !== 1'b1 || ovr_l !== 1'b1)
      $display("FAIL b2b_ovr_lsb got dout=%h v=%b o=%b want a5 1 1",
               dout_l, dv_l, ovr_l);
    else pass_cnt++;
    total++;
    if (dout_m !== 8'hA5 || dv_m !== 1'b1 || ovr_m !== 1'b1)
      $display("FAIL b2b_ovr_msb got dout=%h v=%b o=%b want a5 1 1",
               dout_m, dv_m, ovr_m);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    total++;
    if (dv_l !== 1'b0 || ovr_l !== 1'b1 || dout_l !== 8'hA5)
      $display("FAIL b2b_accept got v=%b o=%b dout=%h want 0 1 a5",
               dv_l, ovr_l, dout_l);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    total++;
    if (ovr_l !== 1'b0 || ovr_m !== 1'b0)
      $display("FAIL b2b_clr got %b/%b want 0/0", ovr_l, ovr_m);
    else pass_cnt++;
  endtask

  task automatic test_frame_start();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    total++;
    if (sel_l !== 3'd1 || sel_m !== 3'd1)
      $display("FAIL fs_sel got %0d/%0d want 1/1", sel_l, sel_m);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    idle();
    total++;
    if (dv_l !== 1'b0 || sel_l !== 3'd7)
      $display("FAIL fs_partial got v=%b sel=%0d want v=0 sel=7", dv_l, sel_l);
    else pass_cnt++;
    send_bit(1'b1);
    idle();
    total++;
    if (dv_l !== 1'b1 || dout_l !== 8'hFF || dout_m !== 8'hFF)
      $display("FAIL fs_byte got v=%b dout=%h/%h want 1 ff/ff",
               dv_l, dout_l, dout_m);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    total++;
    if (sel_l !== 3'd0 || sel_m !== 3'd0 || dv_l !== 1'b0)
      $display("FAIL fs_sync got sel=%0d/%0d v=%b want 0/0 0",
               sel_l, sel_m, dv_l);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [7:0] bits;
    bits = 8'h81;
    for (int i = 0; i < 8; i++) begin
      send_bit(bits[i]);
      idle();
      if (i % 2 == 0) idle();
      if (i == 2) begin
        total++;
        if (sel_l !== 3'd3)
          $display("FAIL gaps_sel got %0d want 3", sel_l);
        else pass_cnt++;
      end
    end
    total++;
    if (dv_l !== 1'b1 || dout_l !== 8'h81 || dout_m !== 8'h81)
      $display("FAIL gaps_byte got v=%b dout=%h/%h want 1 81/81",
               dv_l, dout_l, dout_m);
    else pass_cnt++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    idle();
    total++;
    if (sel_l !== 3'd4 || dout_l !== 8'h81)
      $display("FAIL pre_rst got sel=%0d dout=%h want 4 81", sel_l, dout_l);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({sel_l, dout_l, dv_l, ovr_l} !== 13'd0 ||
        {sel_m, dout_m, dv_m, ovr_m} !== 13'd0)
      $display("FAIL async_rst got sel=%0d dout=%h v=%b o=%b want 0",
               sel_l, dout_l, dv_l, ovr_l);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h0F);
    idle();
    total++;
    if (dv_l !== 1'b1 || dout_l !== 8'h0F || dout_m !== 8'hF0)
      $display("FAIL post_rst got v=%b dout=%h/%h want 1 0f/f0",
               dv_l, dout_l, dout_m);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_start();
    test_gaps();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
